writeback: RTL and testbench
============================

# writeback

MEM/WB pipeline register and writeback stage of the RISC-V core. Captures the memory stage's ALU result and raw load word, then performs byte-lane selection, sign or zero extension and result-source selection. Drives the register-file write port and the forwarding path. Also flags misaligned loads and optionally counts retired instructions.

## Interface
Parameters:
- `OPERAND_WIDTH`, 32 (from `common`): datapath width.
- `REG_ADDR_W`, 5: register index width.
- `INSTRET_W`, 64: retired-instruction counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  hold the MEM/WB register contents.
- `flush`  in  1  invalidate the incoming instruction.
- `in_valid`  in  1  MEM stage holds a real instruction.
- `alu_result`  in  OPERAND_WIDTH  ALU result; also the load/store address.
- `mem_data`  in  32  raw word read from data memory at the word-aligned address.
- `pc_plus4`  in  OPERAND_WIDTH  link value for JAL/JALR.
- `rd`  in  REG_ADDR_W  destination register.
- `ctrl_reg_write`  in  1  instruction writes `rd`.
- `ctrl_mem_read`  in  1  instruction is a load.
- `ctrl_word_size`  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `ctrl_wb_sel`  in  2  result source: 00 ALU, 01 load, 10 pc_plus4, 11 reserved (treated as 00).
- `wb_en`  out  1  register-file write enable.
- `wb_rd`  out  REG_ADDR_W  register-file write index.
- `wb_data`  out  OPERAND_WIDTH  register-file write data and forwarding value.
- `misalign_err`  out  1  one-cycle pulse for a misaligned load.
- `misalign_addr`  out  OPERAND_WIDTH  address of the last misaligned load.
- `instret`  out  INSTRET_W  retired count; present only with `WB_INSTRET_EN`.

## Operation
- **MEM/WB register.** Stores valid, `alu_result`, `mem_data`, `pc_plus4`, `rd`, `ctrl_reg_write`, `ctrl_mem_read`, `ctrl_word_size` and `ctrl_wb_sel`.
  - `flush`=1: the valid bit loads 0 and the other fields are don't-care.
  - Otherwise, `stall`=1: every field holds.
  - Otherwise: every field loads and valid loads `in_valid`.
- **Load extraction.** Uses the registered address, `a = alu_result[1:0]`.
  - Byte loads: byte lane = `mem_data[8*a +: 8]`.
  - Half loads: half lane = `mem_data[16*a[1] +: 16]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - Any other funct3 value is handled as LW.
- **Misalignment.** A load is misaligned when:
  - LH/LHU with `a[0]`=1, or
  - LW with `a`≠0.
- **Writeback.**
  - `wb_data` is the source selected by `ctrl_wb_sel`.
  - `wb_rd` = registered `rd`.
  - `wb_en` = valid & `ctrl_reg_write` & (`rd`≠0) & ~misaligned.
- **Misaligned load handling.**
  - `misalign_err` pulses for one cycle on the first registered cycle of a valid misaligned load.
  - No further pulse while the same instruction is held by `stall`.
  - `misalign_addr` latches `alu_result` on that pulse and holds until the next one.
- **Reset.** Valid=0 and all registered fields=0, so `wb_en`=0, `wb_rd`=0, `wb_data`=0, `misalign_err`=0, `misalign_addr`=0 and `instret`=0.

## Timing
- **Latency.** Inputs sampled at edge N appear on `wb_*` after edge N. The `wb_*` outputs are combinational from the register only and do not depend on any current-cycle input.
- **Register-file write.** Happens at edge N+1, so the write completes one cycle after capture.
- **`stall`.** The `wb_*` outputs stay constant and `wb_en` stays asserted while held. Repeated writes of the same value are permitted.
- **`flush` and `stall` together.** `flush` wins: valid clears.
- **Reset mid-operation.** Asserting `rst` clears valid immediately (asynchronously), so `wb_en` deasserts without waiting for a clock edge. Deassertion is synchronised externally.
- **`misalign_err`.** Driven from a registered "already reported" flag. The flag clears whenever new contents are loaded into the MEM/WB register.

## Configuration
- **Macro `WB_INSTRET_EN`.**
  - Defined: the `instret` port and an INSTRET_W-bit counter exist.
  - The counter increments by 1 at each edge where the register holds a valid, non-misaligned instruction and is not stalled. Each instruction is therefore counted once.
  - The counter wraps from all-ones to 0.
- **Undefined:** the `instret` port and the counter are absent. All other behaviour is identical.

## Test plan
- **Byte loads.** LB with `a`=2, `mem_data`=0x12F45678, `rd`=5 → `wb_data`=0xFFFFFFF4, `wb_en`=1. The same stimulus as LBU → `wb_data`=0x000000F4.
- **Half load and x0.** LH with `a`=2, `mem_data`=0x80017FFF → `wb_data`=0xFFFF8001. With `rd`=0 → `wb_en`=0.
- **Misaligned load.** LW with `alu_result`=0x00000106 → `wb_en`=0, `misalign_err` high for exactly 1 cycle, `misalign_addr`=0x00000106. Holding `stall` for 3 cycles produces no second pulse.
- **Source select.** `ctrl_wb_sel`=10, `pc_plus4`=0x00000404 → `wb_data`=0x404. `ctrl_wb_sel`=11, `alu_result`=0x7 → `wb_data`=0x7.
- **Stall, flush and reset.**
  - `stall`=1 and `flush`=1 together → `wb_en`=0 after the edge.
  - Asserting `rst` low between edges → `wb_en`=0 immediately.
- **With `WB_INSTRET_EN`.**
  - 10 valid instructions with 4 stall cycles interleaved → `instret`=10.
  - Preloading the counter to all-ones, then retiring one instruction → `instret`=0.

Source files
------------

// File: rtl/writeback.sv
// MEM/WB pipeline register and writeback stage: load lane extraction, result select, misaligned-load reporting.
// Optional retired-instruction counter and `instret` port are enabled by defining WB_INSTRET_EN.
module writeback #(
    parameter int OPERAND_WIDTH = 32,
    parameter int REG_ADDR_W    = 5,
    parameter int INSTRET_W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [OPERAND_WIDTH-1:0] alu_result,
    input  logic [31:0]              mem_data,
    input  logic [OPERAND_WIDTH-1:0] pc_plus4,
    input  logic [REG_ADDR_W-1:0]    rd,
    input  logic                     ctrl_reg_write,
    input  logic                     ctrl_mem_read,
    input  logic [2:0]               ctrl_word_size,
    input  logic [1:0]               ctrl_wb_sel,
    output logic                     wb_en,
    output logic [REG_ADDR_W-1:0]    wb_rd,
    output logic [OPERAND_WIDTH-1:0] wb_data,
    output logic                     misalign_err,
    output logic [OPERAND_WIDTH-1:0] misalign_addr
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0]     instret
`endif
);

    logic                     v_q;
    logic [OPERAND_WIDTH-1:0] alu_q;
    logic [31:0]              mem_q;
    logic [OPERAND_WIDTH-1:0] pc4_q;
    logic [REG_ADDR_W-1:0]    rd_q;
    logic                     rw_q;
    logic                     mr_q;
    logic [2:0]               ws_q;
    logic [1:0]               sel_q;
    logic                     reported_q;
    logic [OPERAND_WIDTH-1:0] maddr_q;

    logic [1:0]               a;
    logic [7:0]               byte_lane;
    logic [15:0]              half_lane;
    logic                     is_byte;
    logic                     is_half;
    logic                     is_word;
    logic                     misaligned;
    logic [OPERAND_WIDTH-1:0] load_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q        <= 1'b0;
            alu_q      <= '0;
            mem_q      <= '0;
            pc4_q      <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            mr_q       <= 1'b0;
            ws_q       <= '0;
            sel_q      <= '0;
            reported_q <= 1'b0;
            maddr_q    <= '0;
        end else begin
            if (flush)       v_q <= 1'b0;
            else if (!stall) v_q <= in_valid;
            // payload fields are don't-care under flush, so they simply follow stall
            if (!stall) begin
                alu_q <= alu_result;
                mem_q <= mem_data;
                pc4_q <= pc_plus4;
                rd_q  <= rd;
                rw_q  <= ctrl_reg_write;
                mr_q  <= ctrl_mem_read;
                ws_q  <= ctrl_word_size;
                sel_q <= ctrl_wb_sel;
            end
            reported_q <= (flush || !stall) ? 1'b0 : (reported_q | misalign_err);
            if (misalign_err) maddr_q <= alu_q;
        end
    end

    assign a         = alu_q[1:0];
    assign byte_lane = mem_q[{a, 3'b000} +: 8];
    assign half_lane = mem_q[{a[1], 4'b0000} +: 16];
    // funct3[1:0] picks the access size; unlisted encodings fall into the word case
    assign is_byte   = (ws_q[1:0] == 2'b00);
    assign is_half   = (ws_q[1:0] == 2'b01);
    assign is_word   = ws_q[1];

    always_comb begin
        load_data = OPERAND_WIDTH'(mem_q);
        if (is_byte)
            load_data = {{(OPERAND_WIDTH-8){byte_lane[7] & ~ws_q[2]}}, byte_lane};
        else if (is_half)
            load_data = {{(OPERAND_WIDTH-16){half_lane[15] & ~ws_q[2]}}, half_lane};
    end

    assign misaligned = v_q & mr_q & ((is_half & a[0]) | (is_word & (a != 2'b00)));

    always_comb begin
        wb_data = alu_q;
        case (sel_q)
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = pc4_q;
            default: wb_data = alu_q;
        endcase
    end

    assign wb_rd         = rd_q;
    assign wb_en         = v_q & rw_q & (rd_q != '0) & ~misaligned;
    assign misalign_err  = misaligned & ~reported_q;
    assign misalign_addr = misalign_err ? alu_q : maddr_q;

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;

    // counting only on non-stalled edges retires each held instruction exactly once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret_q <= '0;
        else if (v_q && !misaligned && !stall)
            instret_q <= instret_q + 1'b1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid;
    logic [31:0] alu_result, mem_data, pc_plus4;
    logic [4:0]  rd;
    logic        ctrl_reg_write, ctrl_mem_read;
    logic [2:0]  ctrl_word_size;
    logic [1:0]  ctrl_wb_sel;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic [31:0] misalign_addr;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    writeback dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_result(alu_result), .mem_data(mem_data), .pc_plus4(pc_plus4), .rd(rd),
        .ctrl_reg_write(ctrl_reg_write), .ctrl_mem_read(ctrl_mem_read),
        .ctrl_word_size(ctrl_word_size), .ctrl_wb_sel(ctrl_wb_sel),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err), .misalign_addr(misalign_addr)
`ifdef WB_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        en;
        logic [4:0]  rdv;
        logic        chk;
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step(input logic v, input logic st, input logic fl,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                        input logic [4:0] rdi, input logic rw, input logic mr,
                        input logic [2:0] ws, input logic [1:0] sel,
                        input logic e_en, input logic [4:0] e_rd, input logic e_chk,
                        input logic [31:0] e_data, input logic e_err, input logic [31:0] e_addr,
                        input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        in_valid = v; stall = st; flush = fl;
        alu_result = alu; mem_data = mem; pc_plus4 = pc4; rd = rdi;
        ctrl_reg_write = rw; ctrl_mem_read = mr; ctrl_word_size = ws; ctrl_wb_sel = sel;
        e.nm = nm; e.en = e_en; e.rdv = e_rd; e.chk = e_chk;
        e.data = e_data; e.err = e_err; e.addr = e_addr;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] e_addr, input string nm);
        step(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 3'b000, 2'b00,
             0, 5'd0, 0, 32'h0, 0, e_addr, nm);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    // Monitor: one expectation per issued cycle, checked at the negedge after capture.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (wb_en !== e.en || misalign_err !== e.err || misalign_addr !== e.addr ||
                    (e.en && wb_rd !== e.rdv) || (e.chk && wb_data !== e.data)) begin
                    n_bad++;
                    $display("FAIL %s: got en=%0b rd=%0d data=%h err=%0b addr=%h, want en=%0b rd=%0d data=%h err=%0b addr=%h",
                             e.nm, wb_en, wb_rd, wb_data, misalign_err, misalign_addr,
                             e.en, e.rdv, e.data, e.err, e.addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; stall = 0; flush = 0; in_valid = 0;
        alu_result = 0; mem_data = 0; pc_plus4 = 0; rd = 0;
        ctrl_reg_write = 0; ctrl_mem_read = 0; ctrl_word_size = 0; ctrl_wb_sel = 0;
        #2;
        chk("reset_wb_en", {63'd0, wb_en}, 64'd0);
        chk("reset_wb_rd", {59'd0, wb_rd}, 64'd0);
        chk("reset_wb_data", {32'd0, wb_data}, 64'd0);
        chk("reset_misalign", {31'd0, misalign_err, misalign_addr}, 64'd0);
`ifdef WB_INSTRET_EN
        chk("reset_instret", instret, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // loads: v st fl alu mem pc4 rd rw mr ws sel | en rd chk data err addr
        step(1,0,0, 32'h1002, 32'h12F45678, 0, 5'd5, 1,1, 3'b000, 2'b01, 1,5'd5,1, 32'hFFFFFFF4, 0,32'h0, "lb_a2");
        step(1,0,0, 32'h1002, 32'h12F45678, 0, 5'd5, 1,1, 3'b100, 2'b01, 1,5'd5,1, 32'h000000F4, 0,32'h0, "lbu_a2");
        step(1,0,0, 32'h2002, 32'h80017FFF, 0, 5'd6, 1,1, 3'b001, 2'b01, 1,5'd6,1, 32'hFFFF8001, 0,32'h0, "lh_a2");
        step(1,0,0, 32'h2002, 32'h80017FFF, 0, 5'd6, 1,1, 3'b101, 2'b01, 1,5'd6,1, 32'h00008001, 0,32'h0, "lhu_a2");
        step(1,0,0, 32'h2000, 32'h80017FFF, 0, 5'd6, 1,1, 3'b001, 2'b01, 1,5'd6,1, 32'h00007FFF, 0,32'h0, "lh_a0");
        step(1,0,0, 32'h2002, 32'h80017FFF, 0, 5'd0, 1,1, 3'b001, 2'b01, 0,5'd0,1, 32'hFFFF8001, 0,32'h0, "lh_x0");
        step(1,0,0, 32'h3000, 32'hDEADBEEF, 0, 5'd7, 1,1, 3'b010, 2'b01, 1,5'd7,1, 32'hDEADBEEF, 0,32'h0, "lw_a0");
        step(1,0,0, 32'h3003, 32'h80FF0102, 0, 5'd7, 1,1, 3'b000, 2'b01, 1,5'd7,1, 32'hFFFFFF80, 0,32'h0, "lb_a3");
        step(1,0,0, 32'h3000, 32'h80FF0102, 0, 5'd7, 1,1, 3'b100, 2'b01, 1,5'd7,1, 32'h00000002, 0,32'h0, "lbu_a0");
        step(1,0,0, 32'h3301, 32'h80FF0102, 0, 5'd7, 1,1, 3'b000, 2'b01, 1,5'd7,1, 32'h00000001, 0,32'h0, "lb_a1");

        // misaligned LW, then held by stall: single pulse, address retained
        step(1,0,0, 32'h0106, 32'h11223344, 0, 5'd8, 1,1, 3'b010, 2'b01, 0,5'd8,0, 32'h0, 1,32'h106, "lw_mis");
        for (int i = 0; i < 3; i++)
            step(1,1,0, 32'h0, 32'h0, 0, 5'd9, 1,0, 3'b000, 2'b00, 0,5'd8,0, 32'h0, 0,32'h106, "lw_mis_stall");
        idle(32'h106, "mis_release");
        step(1,0,0, 32'h0201, 32'h0, 0, 5'd8, 1,1, 3'b101, 2'b01, 0,5'd8,0, 32'h0, 1,32'h201, "lhu_mis");
        step(1,0,0, 32'h0202, 32'hABCD0000, 0, 5'd8, 1,1, 3'b101, 2'b01, 1,5'd8,1, 32'h0000ABCD, 0,32'h201, "lhu_ok");
        step(1,0,0, 32'h0302, 32'hCAFEF00D, 0, 5'd8, 1,1, 3'b011, 2'b01, 0,5'd8,0, 32'h0, 1,32'h302, "f3_011_mis");
        step(1,0,0, 32'h0300, 32'hCAFEF00D, 0, 5'd8, 1,1, 3'b011, 2'b01, 1,5'd8,1, 32'hCAFEF00D, 0,32'h302, "f3_011_word");
        step(1,0,0, 32'h0106, 32'h0, 0, 5'd8, 1,0, 3'b010, 2'b00, 1,5'd8,1, 32'h00000106, 0,32'h302, "alu_not_load");

        // result source select
        step(1,0,0, 32'h0, 32'h0, 32'h404, 5'd9, 1,0, 3'b000, 2'b10, 1,5'd9,1, 32'h00000404, 0,32'h302, "sel_pc4");
        step(1,0,0, 32'h7, 32'h0, 32'h404, 5'd9, 1,0, 3'b000, 2'b11, 1,5'd9,1, 32'h00000007, 0,32'h302, "sel_rsvd");
        step(1,0,0, 32'h12345678, 32'h0, 0, 5'd31, 1,0, 3'b000, 2'b00, 1,5'd31,1, 32'h12345678, 0,32'h302, "sel_alu");
        step(1,0,0, 32'h5, 32'h0, 0, 5'd9, 0,0, 3'b000, 2'b00, 0,5'd9,1, 32'h5, 0,32'h302, "no_reg_write");

        // stall holds a valid write, stall+flush clears it, flush alone drops input
        step(1,0,0, 32'h55, 32'h0, 0, 5'd10, 1,0, 3'b000, 2'b00, 1,5'd10,1, 32'h55, 0,32'h302, "pre_stall");
        step(1,1,0, 32'h99, 32'h0, 0, 5'd11, 1,0, 3'b000, 2'b00, 1,5'd10,1, 32'h55, 0,32'h302, "stall_hold1");
        step(1,1,0, 32'h99, 32'h0, 0, 5'd11, 1,0, 3'b000, 2'b00, 1,5'd10,1, 32'h55, 0,32'h302, "stall_hold2");
        step(1,1,1, 32'h99, 32'h0, 0, 5'd11, 1,0, 3'b000, 2'b00, 0,5'd0,0, 32'h0, 0,32'h302, "stall_flush");
        step(1,0,1, 32'h99, 32'h0, 0, 5'd11, 1,0, 3'b000, 2'b00, 0,5'd0,0, 32'h0, 0,32'h302, "flush_only");
        step(1,0,0, 32'hAB, 32'h0, 0, 5'd12, 1,0, 3'b000, 2'b00, 1,5'd12,1, 32'hAB, 0,32'h302, "pre_rst");

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        chk("wb_en_before_rst", {63'd0, wb_en}, 64'd1);
        rst = 1'b0;
        #1;
        chk("wb_en_async_rst", {63'd0, wb_en}, 64'd0);
        chk("misalign_addr_rst", {32'd0, misalign_addr}, 64'd0);
        in_valid = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;

`ifdef WB_INSTRET_EN
        for (int i = 0; i < 10; i++) begin
            step(1,0,0, i, 32'h0, 0, 5'(i+1), 1,0, 3'b000, 2'b00, 1,5'(i+1),1, i, 0,32'h0, "ret_instr");
            if (i % 3 == 0)
                step(1,1,0, 32'hFF, 32'h0, 0, 5'd1, 1,0, 3'b000, 2'b00, 1,5'(i+1),1, i, 0,32'h0, "ret_stall");
        end
        idle(32'h0, "ret_drain");
        @(negedge clk);
        #2;
        chk("instret_ten", instret, 64'd10);
        force dut.instret_q = '1;
        #1;
        release dut.instret_q;
        #1;
        chk("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1,0,0, 32'h1, 32'h0, 0, 5'd3, 1,0, 3'b000, 2'b00, 1,5'd3,1, 32'h1, 0,32'h0, "wrap_instr");
        idle(32'h0, "wrap_drain");
        @(negedge clk);
        #2;
        chk("instret_wrap", instret, 64'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
